// File: rtl/mips_boot_sequencer.sv
// Boot/session sequencer for the MIPS core. It resets the core, loads the I/D cache images
// from a 32-bit valid/ready stream, pulses start, then supervises the run until halt or timeout.
module mips_boot_sequencer #(
    parameter int MAX_IWORDS     = 1024,
    parameter int MAX_DWORDS     = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CLR_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        halt_in,
    output logic        core_rst,
    output logic        icache_we,
    output logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        dcache_we,
    output logic [31:0] daddr,
    output logic [31:0] ddata,
    output logic        core_start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] run_cycles
);

    // state  | meaning
    // IDLE   | waiting for go; core held in reset until the first session
    // CLR    | core_rst asserted for CLR_CYCLES cycles
    // IHDR   | expecting the instruction word count
    // ILOAD  | streaming instruction words into the I-cache
    // DHDR   | expecting the data word count
    // DLOAD  | streaming data words into the D-cache
    // LAUNCH | single-cycle core_start pulse
    // RUN    | core executing; counting cycles until halt or timeout
    // DONE   | run ended by halt_in
    // ERR    | session failed; err_code says why
    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_IHDR, S_ILOAD, S_DHDR, S_DLOAD, S_LAUNCH, S_RUN, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAXI   = MAX_IWORDS;
    localparam logic [31:0] MAXD   = MAX_DWORDS;
    localparam logic [31:0] TO     = TIMEOUT_CYCLES;
    localparam logic [15:0] CLR_M1 = 16'(CLR_CYCLES - 1);

    state_t      state_q, state_d;
    logic        hold_q, hold_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        iwe_q, iwe_d;
    logic [15:0] iaddr_q, iaddr_d;
    logic [31:0] idata_q, idata_d;
    logic        dwe_q, dwe_d;
    logic [15:0] daddr_q, daddr_d;
    logic [31:0] ddata_q, ddata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] run_q, run_d;

    logic        accept;
    logic [15:0] hdr_n;
    logic [31:0] hdr_n32;
    logic [31:0] run_inc;
    logic        last_word;

    assign s_ready    = (state_q == S_IHDR) || (state_q == S_ILOAD) ||
                        (state_q == S_DHDR) || (state_q == S_DLOAD);
    assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign core_start = (state_q == S_LAUNCH);
    assign core_rst   = hold_q || (state_q == S_CLR);

    assign accept    = s_valid && s_ready;
    assign hdr_n     = s_data[15:0];
    assign hdr_n32   = {16'd0, hdr_n};
    assign run_inc   = run_q + 32'd1;
    assign last_word = (idx_q == cnt_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        clr_cnt_d = clr_cnt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        iwe_d     = 1'b0;
        iaddr_d   = iaddr_q;
        idata_d   = idata_q;
        dwe_d     = 1'b0;
        daddr_d   = daddr_q;
        ddata_d   = ddata_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        run_d     = run_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (go && !abort) begin
                    state_d   = S_CLR;
                    hold_d    = 1'b0;
                    clr_cnt_d = CLR_M1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = 2'd0;
                    run_d     = 32'd0;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == 16'd0) begin
                    state_d = S_IHDR;
                end else begin
                    clr_cnt_d = clr_cnt_q - 16'd1;
                end
            end
            S_IHDR: begin
                if (accept) begin
                    if (hdr_n == 16'd0) begin
                        state_d = S_DHDR;
                    end else if (hdr_n32 > MAXI) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_ILOAD;
                        cnt_d   = hdr_n;
                        idx_d   = 16'd0;
                    end
                end
            end
            S_ILOAD: begin
                if (accept) begin
                    iwe_d   = 1'b1;
                    iaddr_d = idx_q;
                    idata_d = s_data;
                    idx_d   = idx_q + 16'd1;
                    if (last_word) begin
                        state_d = S_DHDR;
                    end
                end
            end
            S_DHDR: begin
                if (accept) begin
                    if (hdr_n == 16'd0) begin
                        state_d = S_LAUNCH;
                    end else if (hdr_n32 > MAXD) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_DLOAD;
                        cnt_d   = hdr_n;
                        idx_d   = 16'd0;
                    end
                end
            end
            S_DLOAD: begin
                if (accept) begin
                    dwe_d   = 1'b1;
                    daddr_d = idx_q;
                    ddata_d = s_data;
                    idx_d   = idx_q + 16'd1;
                    if (last_word) begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                run_d = (run_q == 32'hFFFF_FFFF) ? run_q : run_inc;
                // halt has priority over a timeout landing on the same cycle
                if (halt_in) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (run_inc == TO) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any busy-state transition; a write captured this cycle still lands.
        if (busy && abort) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= 1'b1;
            clr_cnt_q <= 16'd0;
            idx_q     <= 16'd0;
            cnt_q     <= 16'd0;
            iwe_q     <= 1'b0;
            iaddr_q   <= 16'd0;
            idata_q   <= 32'd0;
            dwe_q     <= 1'b0;
            daddr_q   <= 16'd0;
            ddata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            run_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            clr_cnt_q <= clr_cnt_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            iwe_q     <= iwe_d;
            iaddr_q   <= iaddr_d;
            idata_q   <= idata_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            ddata_q   <= ddata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            run_q     <= run_d;
        end
    end

    assign icache_we  = iwe_q;
    assign iaddr      = {16'd0, iaddr_q};
    assign idata      = idata_q;
    assign dcache_we  = dwe_q;
    assign daddr      = {16'd0, daddr_q};
    assign ddata      = ddata_q;
    assign done       = done_q;
    assign error      = err_q;
    assign err_code   = code_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Self-checking bench for mips_boot_sequencer: cache writes are scoreboarded against
// expectations queued as words are streamed; session outcomes checked directly.
module tb_mips_boot_sequencer;

    localparam int TO_CYC = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        go, abort, s_valid, halt_in;
    logic [31:0] s_data;
    logic        s_ready, core_rst, icache_we, dcache_we, core_start, busy, done, error;
    logic [31:0] iaddr, idata, daddr, ddata, run_cycles;
    logic [1:0]  err_code;

    mips_boot_sequencer #(
        .MAX_IWORDS(1024), .MAX_DWORDS(1024), .TIMEOUT_CYCLES(TO_CYC), .CLR_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .halt_in(halt_in), .core_rst(core_rst), .icache_we(icache_we),
        .iaddr(iaddr), .idata(idata), .dcache_we(dcache_we), .daddr(daddr), .ddata(ddata),
        .core_start(core_start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] ihdr;
        logic [31:0] dhdr;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_starts;
    } vec_t;

    wr_t iq[$];
    wr_t dq[$];
    int  cmp_cnt = 0;
    int  err_cnt = 0;
    int  start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (icache_we) begin
                if (iq.size() == 0) begin
                    chk("unexpected_icache_we", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = iq.pop_front();
                    chk("iaddr", iaddr, e.addr);
                    chk("idata", idata, e.data);
                end
            end
            if (dcache_we) begin
                if (dq.size() == 0) begin
                    chk("unexpected_dcache_we", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = dq.pop_front();
                    chk("daddr", daddr, e.addr);
                    chk("ddata", ddata, e.data);
                end
            end
            if (core_start) start_cnt++;
        end
    end

    // kind: 0 header, 1 instruction word, 2 data word
    task automatic send_word(input logic [31:0] w, input int kind, input logic [31:0] addr);
        int n;
        wr_t e;
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_wait", 32'd0, 32'd1);
        e.addr = addr;
        e.data = w;
        if (kind == 1) iq.push_back(e);
        if (kind == 2) dq.push_back(e);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_go();
        int n;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_done", done, 0);
        chk("clr_error", error, 0);
        chk("clr_code", err_code, 0);
        chk("clr_run", run_cycles, 0);
        n = 0;
        while (core_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("core_rst_cycles", n, 2);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) chk("core_start_wait", 32'd0, 32'd1);
    endtask

    // halt_in is sampled on the RUN edge that makes run_cycles reach ncyc
    task automatic run_halt(input int ncyc);
        wait_start();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("busy_run", busy, 1);
                chk("start_single", core_start, 0);
            end
        end
        halt_in = 1'b1;
        @(negedge clk);
        halt_in = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        int s0, n;

        vecs[0] = '{ihdr: 32'h0000_0401, dhdr: 32'h0, exp_err: 1'b1, exp_code: 2'd1, exp_starts: 0};
        vecs[1] = '{ihdr: 32'hABCD_0000, dhdr: 32'h0000_0401, exp_err: 1'b1, exp_code: 2'd1, exp_starts: 0};
        vecs[2] = '{ihdr: 32'hFFFF_0000, dhdr: 32'h1234_0000, exp_err: 1'b0, exp_code: 2'd0, exp_starts: 1};
        vecs[3] = '{ihdr: 32'h0000_FFFF, dhdr: 32'h0, exp_err: 1'b1, exp_code: 2'd1, exp_starts: 0};

        rst = 1'b1; go = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 32'd0; halt_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_icache_we", icache_we, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_error", {error, done, err_code}, 0);
        chk("rst_run", run_cycles, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_core_rst", core_rst, 1);

        // program load + halt after 40 cycles
        s0 = start_cnt;
        do_go();
        send_word(32'd3, 0, 0);
        send_word(32'h2001_0001, 1, 0);
        send_word(32'h2002_0002, 1, 1);
        send_word(32'h0022_1820, 1, 2);
        send_word(32'd0, 0, 0);
        run_halt(40);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_run", run_cycles, 40);
        chk("t1_code", err_code, 0);
        chk("t1_core_rst", core_rst, 0);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_iq_empty", iq.size(), 0);

        // data image with stream gaps
        s0 = start_cnt;
        do_go();
        send_word(32'd0, 0, 0);
        send_word(32'd2, 0, 0);
        @(negedge clk);
        send_word(32'hDEAD_0001, 2, 0);
        @(negedge clk);
        send_word(32'hBEEF_0002, 2, 1);
        run_halt(5);
        chk("t3_done", done, 1);
        chk("t3_run", run_cycles, 5);
        chk("t3_starts", start_cnt - s0, 1);
        chk("t3_dq_empty", dq.size(), 0);

        // timeout, then a fresh go clears flags
        do_go();
        send_word(32'd0, 0, 0);
        send_word(32'd0, 0, 0);
        wait_start();
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_error", error, 1);
        chk("to_code", err_code, 2);
        chk("to_run", run_cycles, TO_CYC);
        chk("to_done", done, 0);
        do_go();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_hdr_code", err_code, 3);
        chk("ab_hdr_busy", busy, 0);
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        chk("go_abort_busy", busy, 0);
        chk("go_abort_code", err_code, 3);

        // abort mid-ILOAD with one word accepted on the abort cycle
        do_go();
        send_word(32'd5, 0, 0);
        send_word(32'h1111_0000, 1, 0);
        send_word(32'h1111_0001, 1, 1);
        send_word(32'h1111_0002, 1, 2);
        abort = 1'b1; s_valid = 1'b1; s_data = 32'h1111_0003;
        chk("ab_s_ready_pre", s_ready, 1);
        iq.push_back('{addr: 32'd3, data: 32'h1111_0003});
        @(negedge clk);
        abort = 1'b0; s_valid = 1'b0;
        chk("ab_s_ready", s_ready, 0);
        chk("ab_error", error, 1);
        chk("ab_code", err_code, 3);
        repeat (3) @(negedge clk);
        chk("ab_iq_empty", iq.size(), 0);

        // header vectors
        foreach (vecs[k]) begin
            s0 = start_cnt;
            do_go();
            send_word(vecs[k].ihdr, 0, 0);
            if (vecs[k].ihdr[15:0] == 16'd0) send_word(vecs[k].dhdr, 0, 0);
            n = 0;
            while (busy && n < 60) begin
                if (core_start) halt_in = 1'b1;
                @(negedge clk);
                n++;
            end
            halt_in = 1'b0;
            chk($sformatf("v%0d_busy", k), busy, 0);
            chk($sformatf("v%0d_error", k), error, vecs[k].exp_err);
            chk($sformatf("v%0d_code", k), err_code, vecs[k].exp_code);
            chk($sformatf("v%0d_done", k), done, (vecs[k].exp_starts != 0));
            chk($sformatf("v%0d_starts", k), start_cnt - s0, vecs[k].exp_starts);
        end

        // asynchronous reset in RUN
        do_go();
        send_word(32'd0, 0, 0);
        send_word(32'd0, 0, 0);
        wait_start();
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_core_rst", core_rst, 1);
        chk("arst_busy", busy, 0);
        chk("arst_run", run_cycles, 0);
        chk("arst_flags", {error, done, err_code, core_start}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_hold", core_rst, 1);
        chk("final_queues", iq.size() + dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
